dcache_ctrl: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache serving the MEM stage of the RV32I pipeline.
- Produces DCacheMiss for the hazard unit, which stalls the whole pipeline while a miss is serviced.
- Talks to main memory through a word-serial request/acknowledge interface.
- Includes access and miss counters for lab measurement.

---
 rtl/cache_pkg.sv | 29 ++
 rtl/dcache_ctrl_if.sv | 29 ++
 rtl/cache_line_array.sv | 68 ++++++
 rtl/dcache_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache:
// address-field widths, FSM state encoding and common word/tag types.
package cache_pkg;

   localparam int unsigned LINE_ADDR_LEN = 3;  // log2(words per line)
   localparam int unsigned SET_ADDR_LEN  = 3;  // log2(number of lines)

   // Tag width is whatever remains of a 32-bit byte address.
   function automatic int unsigned tag_addr_len(input int unsigned line_len,
                                                input int unsigned set_len);
      return 32 - 2 - line_len - set_len;
   endfunction

   function automatic int unsigned pow2(input int unsigned n);
      return 32'd1 << n;
   endfunction

   localparam int unsigned TAG_ADDR_LEN = tag_addr_len(LINE_ADDR_LEN, SET_ADDR_LEN);
   localparam int unsigned LINE_WORDS   = pow2(LINE_ADDR_LEN);
   localparam int unsigned NUM_LINES    = pow2(SET_ADDR_LEN);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WB   = 2'd1;
   localparam logic [1:0] S_FILL = 2'd2;

   typedef logic [31:0]             word_t;
   typedef logic [TAG_ADDR_LEN-1:0] tag_t;

endpackage

// File: rtl/dcache_ctrl_if.sv
// Cache bus bundle: MEM-stage request/response plus the word-serial memory
// request/acknowledge channel.
//   master : pipeline + memory side (drives requests, MemRData, MemAck)
//   slave  : the cache (drives RdData, DCacheMiss and memory beats)
interface dcache_ctrl_if;
   logic        RdReq;
   logic        WrReq;
   logic [31:0] Addr;
   logic [31:0] WrData;
   logic [3:0]  WrBe;
   logic [31:0] RdData;
   logic        DCacheMiss;
   logic        MemReq;
   logic        MemWe;
   logic [31:0] MemAddr;
   logic [31:0] MemWData;
   logic [31:0] MemRData;
   logic        MemAck;

   modport master (
      output RdReq, WrReq, Addr, WrData, WrBe, MemRData, MemAck,
      input  RdData, DCacheMiss, MemReq, MemWe, MemAddr, MemWData
   );

   modport slave (
      input  RdReq, WrReq, Addr, WrData, WrBe, MemRData, MemAck,
      output RdData, DCacheMiss, MemReq, MemWe, MemAddr, MemWData
   );
endinterface

// File: rtl/cache_line_array.sv
// Line storage: valid/dirty/tag per line plus the data words.
// Ports: combinational read port (rd_set/rd_word -> rd_*_c); byte-enabled
// word write port and line-state updates, all addressed by wr_set.
// valid/dirty are reset; tags and data are not.
module cache_line_array
   import cache_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [SET_ADDR_LEN-1:0]  rd_set,
   input  logic [LINE_ADDR_LEN-1:0] rd_word,
   output logic                     rd_valid_c,
   output logic                     rd_dirty_c,
   output tag_t                     rd_tag_c,
   output word_t                    rd_data_c,
   input  logic [SET_ADDR_LEN-1:0]  wr_set,
   input  logic [LINE_ADDR_LEN-1:0] wr_word,
   input  logic                     wr_en,
   input  logic [3:0]               wr_be,
   input  word_t                    wr_data,
   input  logic                     set_dirty,
   input  logic                     clr_dirty,
   input  logic                     clr_valid,
   input  logic                     fill_done,
   input  tag_t                     fill_tag
);

   logic [NUM_LINES-1:0] valid_q, valid_d;
   logic [NUM_LINES-1:0] dirty_q, dirty_d;
   tag_t                 tag_q  [NUM_LINES];
   word_t                data_q [NUM_LINES*LINE_WORDS];

   assign rd_valid_c = valid_q[rd_set];
   assign rd_dirty_c = dirty_q[rd_set];
   assign rd_tag_c   = tag_q[rd_set];
   assign rd_data_c  = data_q[{rd_set, rd_word}];

   // Line state updates; a completed fill makes the line valid and clean.
   always_comb begin
      valid_d = valid_q;
      dirty_d = dirty_q;
      if (clr_valid) valid_d[wr_set] = 1'b0;
      if (fill_done) valid_d[wr_set] = 1'b1;
      if (set_dirty) dirty_d[wr_set] = 1'b1;
      if (clr_dirty || fill_done) dirty_d[wr_set] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         valid_q <= valid_d;
         dirty_q <= dirty_d;
      end
   end

   // Tag and data storage (not reset).
   always_ff @(posedge clk) begin
      if (fill_done) tag_q[wr_set] <= fill_tag;
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) data_q[{wr_set, wr_word}][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage.
// Ports: clk, rst_n (async active-low); bus (slave side of dcache_ctrl_if:
// load/store request, RdData/DCacheMiss, word-serial memory channel);
// AccessCount/MissCount measurement counters.
// Hits answer combinationally; a miss stalls via DCacheMiss while the FSM
// writes back a dirty victim (WB) and refills the line (FILL).
module dcache_ctrl
   import cache_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   dcache_ctrl_if.slave bus,
   output logic [31:0] AccessCount,
   output logic [31:0] MissCount
);

   logic [1:0]               state_q, state_d;
   logic [LINE_ADDR_LEN-1:0] cnt_q, cnt_d;
   logic [SET_ADDR_LEN-1:0]  miss_set_q, miss_set_d;
   tag_t                     miss_tag_q, miss_tag_d;
   logic                     refill_q, refill_d;
   logic [31:0]              access_q, access_d;
   logic [31:0]              miss_q, miss_d;

   logic [LINE_ADDR_LEN-1:0] req_word;
   logic [SET_ADDR_LEN-1:0]  req_set;
   tag_t                     req_tag;
   logic                     req;
   logic                     hit;
   logic                     addr_unused;

   logic [SET_ADDR_LEN-1:0]  rd_set;
   logic [LINE_ADDR_LEN-1:0] rd_word;
   logic                     rd_valid_c, rd_dirty_c;
   tag_t                     rd_tag_c;
   word_t                    rd_data_c;
   logic [SET_ADDR_LEN-1:0]  wr_set;
   logic [LINE_ADDR_LEN-1:0] wr_word;
   logic                     wr_en;
   logic [3:0]               wr_be;
   word_t                    wr_data;
   logic                     set_dirty, clr_dirty, clr_valid, fill_done;

   assign req_word    = bus.Addr[LINE_ADDR_LEN+1:2];
   assign req_set     = bus.Addr[LINE_ADDR_LEN+2 +: SET_ADDR_LEN];
   assign req_tag     = bus.Addr[31 -: TAG_ADDR_LEN];
   assign addr_unused = ^bus.Addr[1:0];
   assign req         = bus.RdReq | bus.WrReq;

   // In IDLE the read port follows the request; during a miss it walks the
   // victim line beat by beat.
   assign rd_set  = (state_q == S_IDLE) ? req_set  : miss_set_q;
   assign rd_word = (state_q == S_IDLE) ? req_word : cnt_q;
   assign hit     = rd_valid_c && (rd_tag_c == req_tag);

   assign AccessCount = access_q;
   assign MissCount   = miss_q;

   cache_line_array u_lines (
      .clk        (clk),
      .rst_n      (rst_n),
      .rd_set     (rd_set),
      .rd_word    (rd_word),
      .rd_valid_c (rd_valid_c),
      .rd_dirty_c (rd_dirty_c),
      .rd_tag_c   (rd_tag_c),
      .rd_data_c  (rd_data_c),
      .wr_set     (wr_set),
      .wr_word    (wr_word),
      .wr_en      (wr_en),
      .wr_be      (wr_be),
      .wr_data    (wr_data),
      .set_dirty  (set_dirty),
      .clr_dirty  (clr_dirty),
      .clr_valid  (clr_valid),
      .fill_done  (fill_done),
      .fill_tag   (miss_tag_q)
   );

   // Next-state, memory beat and array control.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      miss_set_d = miss_set_q;
      miss_tag_d = miss_tag_q;
      refill_d   = 1'b0;
      access_d   = access_q;
      miss_d     = miss_q;

      bus.RdData     = rd_data_c;
      bus.DCacheMiss = 1'b0;
      bus.MemReq     = 1'b0;
      bus.MemWe      = 1'b0;
      bus.MemAddr    = '0;
      bus.MemWData   = '0;

      wr_set    = rd_set;
      wr_word   = rd_word;
      wr_en     = 1'b0;
      wr_be     = bus.WrBe;
      wr_data   = bus.WrData;
      set_dirty = 1'b0;
      clr_dirty = 1'b0;
      clr_valid = 1'b0;
      fill_done = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req) begin
               if (hit) begin
                  if (bus.WrReq) begin
                     wr_en     = 1'b1;
                     set_dirty = 1'b1;
                  end
                  // The re-hit right after a refill was already counted.
                  if (!refill_q) access_d = access_q + 32'd1;
               end else begin
                  bus.DCacheMiss = 1'b1;
                  access_d       = access_q + 32'd1;
                  miss_d         = miss_q + 32'd1;
                  cnt_d          = '0;
                  miss_set_d     = req_set;
                  miss_tag_d     = req_tag;
                  // Line contents become stale as soon as refill begins.
                  clr_valid      = 1'b1;
                  state_d        = (rd_valid_c && rd_dirty_c) ? S_WB : S_FILL;
               end
            end
         end

         S_WB: begin
            bus.DCacheMiss = 1'b1;
            bus.MemReq     = 1'b1;
            bus.MemWe      = 1'b1;
            bus.MemAddr    = {rd_tag_c, miss_set_q, cnt_q, 2'b00};
            bus.MemWData   = rd_data_c;
            if (bus.MemAck) begin
               cnt_d = cnt_q + LINE_ADDR_LEN'(1);
               if (&cnt_q) begin
                  clr_dirty = 1'b1;
                  state_d   = S_FILL;
               end
            end
         end

         S_FILL: begin
            bus.DCacheMiss = 1'b1;
            bus.MemReq     = 1'b1;
            bus.MemAddr    = {miss_tag_q, miss_set_q, cnt_q, 2'b00};
            if (bus.MemAck) begin
               wr_en   = 1'b1;
               wr_be   = 4'hF;
               wr_data = bus.MemRData;
               cnt_d   = cnt_q + LINE_ADDR_LEN'(1);
               if (&cnt_q) begin
                  fill_done = 1'b1;
                  refill_d  = 1'b1;
                  state_d   = S_IDLE;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         miss_set_q <= '0;
         miss_tag_q <= '0;
         refill_q   <= 1'b0;
         access_q   <= '0;
         miss_q     <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         miss_set_q <= miss_set_d;
         miss_tag_q <= miss_tag_d;
         refill_q   <= refill_d;
         access_q   <= access_d;
         miss_q     <= miss_d;
      end
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: table-driven directed accesses, hand sequences for
// slow memory and mid-miss reset, then random accesses against a
// line-level cache model with its own memory image.
module tb_dcache_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] access_count, miss_count;

   always #5 clk = ~clk;

   dcache_ctrl_if bus ();

   dcache_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .AccessCount (access_count),
      .MissCount   (miss_count)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
   endtask

   // ---------------- memory responder ----------------
   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } beat_t;

   beat_t       beat_log[$];
   logic [31:0] env_mem [logic [31:0]];
   int          ack_delay = 0;

   function automatic logic [31:0] mem_init(input logic [31:0] a);
      return 32'h100 + ((a - 32'h40) >> 2);
   endfunction

   function automatic logic [31:0] env_rd(input logic [31:0] a);
      if (env_mem.exists(a)) return env_mem[a];
      return mem_init(a);
   endfunction

   // Acks each beat after ack_delay waiting cycles; a beat is recorded at
   // the negedge following its acknowledging clock edge.
   initial begin : responder
      int    wait_cnt;
      logic  ack_prev, held;
      beat_t cur;
      wait_cnt = 0; ack_prev = 1'b0; held = 1'b0; cur = '0;
      bus.MemAck = 1'b0;
      bus.MemRData = '0;
      forever begin
         @(negedge clk);
         if (ack_prev && rst_n) begin
            beat_log.push_back(cur);
            if (cur.we) env_mem[cur.addr] = cur.data;
         end
         ack_prev = 1'b0;
         if (!rst_n || !bus.MemReq) begin
            bus.MemAck = 1'b0;
            wait_cnt = 0;
            held = 1'b0;
         end else begin
            if (held) begin
               check("hold_we", 32'(bus.MemWe), 32'(cur.we));
               check("hold_addr", bus.MemAddr, cur.addr);
               if (cur.we) check("hold_wdata", bus.MemWData, cur.data);
            end
            cur.we   = bus.MemWe;
            cur.addr = bus.MemAddr;
            cur.data = bus.MemWe ? bus.MemWData : env_rd(bus.MemAddr);
            bus.MemRData = cur.we ? 32'h0 : cur.data;
            if (wait_cnt >= ack_delay) begin
               bus.MemAck = 1'b1;
               ack_prev = 1'b1;
               wait_cnt = 0;
               held = 1'b0;
            end else begin
               bus.MemAck = 1'b0;
               wait_cnt++;
               held = 1'b1;
            end
         end
      end
   end

   // ---------------- reference model ----------------
   logic        m_valid [8];
   logic        m_dirty [8];
   logic [23:0] m_tag   [8];
   logic [31:0] m_line  [8][8];
   logic [31:0] ref_mem [logic [31:0]];
   int unsigned m_acc, m_mis;

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return mem_init(a);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
      end
      m_acc = 0;
      m_mis = 0;
   endtask

   // One access: checks miss flag, beats, stall length, load data, counters.
   task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be,
                            output logic got_miss, output logic [31:0] got_rdata,
                            output int got_stall);
      int          set, word, stall, exp_stall;
      logic [23:0] tag;
      logic        hit;
      logic [31:0] base_old, base_new;
      beat_t       exp_q[$];
      set  = int'((addr >> 5) & 32'd7);
      word = int'((addr >> 2) & 32'd7);
      tag  = addr[31:8];
      @(negedge clk);
      bus.RdReq = rd; bus.WrReq = wr; bus.Addr = addr; bus.WrData = wdata; bus.WrBe = be;
      beat_log.delete();
      #2;
      hit = m_valid[set] && (m_tag[set] == tag);
      got_miss = bus.DCacheMiss;
      check("dcache_miss", 32'(got_miss), 32'(!hit));
      m_acc++;
      stall = 0;
      if (!hit) begin
         m_mis++;
         base_new = {addr[31:5], 5'b0};
         if (m_valid[set] && m_dirty[set]) begin
            base_old = {m_tag[set], addr[7:5], 5'b0};
            for (int w = 0; w < 8; w++) begin
               exp_q.push_back('{1'b1, base_old + 32'(w*4), m_line[set][w]});
               ref_mem[base_old + 32'(w*4)] = m_line[set][w];
            end
         end
         for (int w = 0; w < 8; w++) begin
            m_line[set][w] = ref_rd(base_new + 32'(w*4));
            exp_q.push_back('{1'b0, base_new + 32'(w*4), m_line[set][w]});
         end
         m_valid[set] = 1'b1;
         m_dirty[set] = 1'b0;
         m_tag[set]   = tag;
         exp_stall = 1 + exp_q.size() * (ack_delay + 1);
         stall = 1;
         while (bus.DCacheMiss && stall < 500) begin
            @(negedge clk); #2;
            if (bus.DCacheMiss) stall++;
         end
         check("stall_cycles", 32'(stall), 32'(exp_stall));
         check("beat_count", 32'(beat_log.size()), 32'(exp_q.size()));
         foreach (exp_q[i]) begin
            if (i < beat_log.size()) begin
               check("beat_we", 32'(beat_log[i].we), 32'(exp_q[i].we));
               check("beat_addr", beat_log[i].addr, exp_q[i].addr);
               check("beat_data", beat_log[i].data, exp_q[i].data);
            end
         end
      end
      got_stall = stall;
      got_rdata = bus.RdData;
      if (rd && !wr) check("rd_data", got_rdata, m_line[set][word]);
      if (wr) begin
         for (int b = 0; b < 4; b++)
            if (be[b]) m_line[set][word][8*b +: 8] = wdata[8*b +: 8];
         m_dirty[set] = 1'b1;
      end
      @(negedge clk);
      bus.RdReq = 1'b0; bus.WrReq = 1'b0;
      #2;
      check("access_count", access_count, m_acc);
      check("miss_count", miss_count, m_mis);
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic        rd, wr;
      logic [31:0] addr, wdata;
      logic [3:0]  be;
      logic        exp_miss;
      logic [31:0] exp_rdata, exp_acc, exp_mis;
   } vec_t;

   vec_t vecs[7];

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1);
   end

   initial begin : main
      logic        gm;
      logic [31:0] gr, ra;
      int          gs, sel;

      vecs[0] = '{1'b1, 1'b0, 32'h40,  32'h0,        4'h0, 1'b1, 32'h100,      32'd1, 32'd1};
      vecs[1] = '{1'b1, 1'b0, 32'h48,  32'h0,        4'h0, 1'b0, 32'h102,      32'd2, 32'd1};
      vecs[2] = '{1'b0, 1'b1, 32'h44,  32'hAABBCCDD, 4'h3, 1'b0, 32'h0,        32'd3, 32'd1};
      vecs[3] = '{1'b1, 1'b0, 32'h44,  32'h0,        4'h0, 1'b0, 32'h0000CCDD, 32'd4, 32'd1};
      vecs[4] = '{1'b1, 1'b0, 32'h440, 32'h0,        4'h0, 1'b1, 32'h200,      32'd5, 32'd2};
      vecs[5] = '{1'b1, 1'b0, 32'h40,  32'h0,        4'h0, 1'b1, 32'h100,      32'd6, 32'd3};
      vecs[6] = '{1'b1, 1'b0, 32'h44,  32'h0,        4'h0, 1'b0, 32'h0000CCDD, 32'd7, 32'd3};

      bus.RdReq = 1'b0; bus.WrReq = 1'b0; bus.Addr = '0; bus.WrData = '0; bus.WrBe = '0;
      model_reset();

      // Reset state
      #12;
      check("rst_memreq", 32'(bus.MemReq), 32'd0);
      check("rst_memwe", 32'(bus.MemWe), 32'd0);
      check("rst_dcachemiss", 32'(bus.DCacheMiss), 32'd0);
      check("rst_access", access_count, 32'd0);
      check("rst_miss", miss_count, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Cold miss, hit, store hit, merged read, dirty conflict, clean refill.
      ack_delay = 0;
      for (int i = 0; i < 7; i++) begin
         do_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, gm, gr, gs);
         check("vec_miss", 32'(gm), 32'(vecs[i].exp_miss));
         if (vecs[i].rd && !vecs[i].wr) check("vec_rdata", gr, vecs[i].exp_rdata);
         check("vec_access", access_count, vecs[i].exp_acc);
         check("vec_misses", miss_count, vecs[i].exp_mis);
      end
      check("vec1_stall", 32'd9, 32'd9 * 32'(vecs[0].exp_miss));

      // Slow memory: 3 wait cycles per beat.
      ack_delay = 3;
      do_access(1'b1, 1'b0, 32'h840, 32'h0, 4'h0, gm, gr, gs);
      check("slow_clean_stall", 32'(gs), 32'd33);
      do_access(1'b0, 1'b1, 32'h85C, 32'h12345678, 4'hF, gm, gr, gs);
      check("slow_store_hit", 32'(gm), 32'd0);
      do_access(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, gm, gr, gs);
      check("slow_dirty_stall", 32'(gs), 32'd65);
      check("slow_dirty_rdata", gr, 32'h100);

      // Reset in the middle of a refill.
      ack_delay = 0;
      @(negedge clk);
      bus.RdReq = 1'b1; bus.Addr = 32'h00F0_0080;
      beat_log.delete();
      for (int c = 0; c < 50 && beat_log.size() < 4; c++) begin
         @(negedge clk); #1;
      end
      check("mid_fill_beats", 32'(beat_log.size()), 32'd4);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_memreq", 32'(bus.MemReq), 32'd0);
      check("abort_access", access_count, 32'd0);
      check("abort_miss", miss_count, 32'd0);
      @(negedge clk);
      @(negedge clk);
      bus.RdReq = 1'b0;
      rst_n = 1'b1;
      model_reset();
      do_access(1'b1, 1'b0, 32'h00F0_0080, 32'h0, 4'h0, gm, gr, gs);
      check("post_abort_miss", 32'(gm), 32'd1);
      check("post_abort_counts", access_count + miss_count, 32'd2);

      // Random traffic over 4 tags x 8 sets.
      for (int n = 0; n < 200; n++) begin
         ack_delay = int'($urandom_range(0, 2));
         ra = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 5) |
              (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
         sel = int'($urandom_range(0, 2));
         do_access(sel != 1, sel != 0, ra, $urandom, 4'($urandom_range(0, 15)), gm, gr, gs);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
